// File: rtl/pid_pwm_out.sv
// PID output stage: captures per-channel signed motor power and drives sign-magnitude PWM.
// All channels share one free-running PWM counter; duty and direction change only at period start.
// Define PID_PWM_DEADTIME_EN to insert forced-low dead periods on direction reversal.
module pid_pwm_out #(
   parameter int unsigned aw       = 1,
   parameter int unsigned an       = 2,
   parameter int unsigned ow       = 12,
   parameter int unsigned deadtime = 2
) (
   input  logic          clk_pid,
   input  logic          reset,
   input  logic          ce,
   input  logic [aw-1:0] a,
   input  logic [ow-1:0] m_k_in,
   output logic [an-1:0] pwm_out,
   output logic [an-1:0] dir_out,
   output logic          wrap
);

   localparam int unsigned pw = ow - 1;

   if (an != (1 << aw)) begin : g_bad_an
      $error("an must equal 1 << aw");
   end
   if (deadtime < 1 || deadtime > 15) begin : g_bad_deadtime
      $error("deadtime must be in 1..15");
   end

`ifdef PID_PWM_DEADTIME_EN
   typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;
   localparam logic [3:0] dt_init = 4'(deadtime - 1);
   logic [3:0] dt_cnt_q [an];
   logic [3:0] dt_cnt_d [an];
`else
   typedef enum logic [0:0] {StIdle, StRun} state_e;
`endif

   logic [ow-1:0] duty_req_q [an];
   logic [pw-1:0] cnt_q;
   logic          wrap_q;
   logic [pw-1:0] duty_act_q [an];
   logic [pw-1:0] duty_act_d [an];
   logic [pw-1:0] mag [an];
   logic [an-1:0] sgn;
   logic [an-1:0] dir_q, dir_d;
   logic [an-1:0] pwm_q, pwm_d;
   state_e        state_q [an];
   state_e        state_d [an];
   logic          period_start;

   // |v| in pw bits; the most negative input saturates to full scale.
   function automatic logic [pw-1:0] sat_mag(input logic [ow-1:0] v);
      logic [ow-1:0] absv;
      absv = v[ow-1] ? -v : v;
      return absv[ow-1] ? {pw{1'b1}} : absv[pw-1:0];
   endfunction

   assign period_start = (cnt_q == '0);

   // Capture the PID result for the addressed channel; a later strobe overwrites.
   always_ff @(posedge clk_pid or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < an; i++) duty_req_q[i] <= '0;
      end else if (ce) begin
         duty_req_q[a] <= m_k_in;
      end
   end

   // Shared PWM counter; wrap is registered so it is high in the cycle where cnt is 0.
   always_ff @(posedge clk_pid or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_q + pw'(1);
         wrap_q <= (cnt_q == '1);
      end
   end

   // Sign and saturated magnitude of each held request.
   always_comb begin
      for (int i = 0; i < an; i++) begin
         sgn[i] = duty_req_q[i][ow-1];
         mag[i] = sat_mag(duty_req_q[i]);
      end
   end

   // Per-channel state register, including duty, direction and PWM output.
   always_ff @(posedge clk_pid or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < an; i++) begin
            state_q[i]    <= StIdle;
            duty_act_q[i] <= '0;
`ifdef PID_PWM_DEADTIME_EN
            dt_cnt_q[i]   <= '0;
`endif
         end
         dir_q <= '0;
         pwm_q <= '0;
      end else begin
         for (int i = 0; i < an; i++) begin
            state_q[i]    <= state_d[i];
            duty_act_q[i] <= duty_act_d[i];
`ifdef PID_PWM_DEADTIME_EN
            dt_cnt_q[i]   <= dt_cnt_d[i];
`endif
         end
         dir_q <= dir_d;
         pwm_q <= pwm_d;
      end
   end

   // Next-state logic, evaluated only at period start so a period never changes mid-way.
   always_comb begin
      for (int i = 0; i < an; i++) begin
         state_d[i]    = state_q[i];
         duty_act_d[i] = duty_act_q[i];
         dir_d[i]      = dir_q[i];
`ifdef PID_PWM_DEADTIME_EN
         dt_cnt_d[i]   = dt_cnt_q[i];
`endif
         if (period_start) begin
            case (state_q[i])
               StIdle: begin
                  // First command takes its direction directly.
                  duty_act_d[i] = mag[i];
                  if (mag[i] != '0) begin
                     dir_d[i]   = sgn[i];
                     state_d[i] = StRun;
                  end
               end
               StRun: begin
                  if (mag[i] != '0 && sgn[i] != dir_q[i]) begin
`ifdef PID_PWM_DEADTIME_EN
                     state_d[i]    = StDead;
                     duty_act_d[i] = '0;
                     dt_cnt_d[i]   = dt_init;
`else
                     dir_d[i]      = sgn[i];
                     duty_act_d[i] = mag[i];
`endif
                  end else begin
                     // Zero power keeps the last direction.
                     duty_act_d[i] = mag[i];
                  end
               end
`ifdef PID_PWM_DEADTIME_EN
               StDead: begin
                  if (dt_cnt_q[i] != '0) begin
                     dt_cnt_d[i] = dt_cnt_q[i] - 4'd1;
                  end else begin
                     duty_act_d[i] = mag[i];
                     if (mag[i] != '0) dir_d[i] = sgn[i];
                     state_d[i] = StRun;
                  end
               end
`endif
               default: state_d[i] = StIdle;
            endcase
         end
      end
   end

   // PWM compare; the registered output lags the counter by one clock.
   always_comb begin
      for (int i = 0; i < an; i++) begin
         pwm_d[i] = (state_q[i] == StRun) && (cnt_q < duty_act_q[i]);
      end
   end

   assign pwm_out = pwm_q;
   assign dir_out = dir_q;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_pid_pwm_out.sv
// Directed bench for pid_pwm_out (ow=12, aw=1, period 2048, deadtime=2).
// Expectations follow PID_PWM_DEADTIME_EN when it is defined.
module tb_pid_pwm_out;

   localparam int unsigned aw = 1;
   localparam int unsigned an = 2;
   localparam int unsigned ow = 12;
   localparam int unsigned period = 2048;

   logic          clk_pid = 1'b0;
   logic          reset;
   logic          ce;
   logic [aw-1:0] a;
   logic [ow-1:0] m_k_in;
   logic [an-1:0] pwm_out;
   logic [an-1:0] dir_out;
   logic          wrap;

   int total = 0;
   int bad   = 0;

   pid_pwm_out #(
      .aw       (aw),
      .an       (an),
      .ow       (ow),
      .deadtime (2)
   ) dut (
      .clk_pid (clk_pid),
      .reset   (reset),
      .ce      (ce),
      .a       (a),
      .m_k_in  (m_k_in),
      .pwm_out (pwm_out),
      .dir_out (dir_out),
      .wrap    (wrap)
   );

   always #5 clk_pid = ~clk_pid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle with wrap high (sampled at negedge), bounded.
   task automatic wait_wrap();
      int n = 0;
      do begin
         @(negedge clk_pid);
         n++;
      end while (wrap !== 1'b1 && n < 2100);
      if (wrap !== 1'b1) chk("wrap_timeout", 32'(wrap), 1);
   endtask

   // Count high samples of each channel and wrap pulses over one full period after a wrap.
   task automatic measure(output int h0, output int h1, output int nw);
      wait_wrap();
      h0 = 0; h1 = 0; nw = 0;
      repeat (period) begin
         @(negedge clk_pid);
         h0 += int'(pwm_out[0]);
         h1 += int'(pwm_out[1]);
         nw += int'(wrap);
      end
   endtask

   task automatic send(input logic [aw-1:0] ch, input logic [ow-1:0] val);
      @(negedge clk_pid);
      ce = 1'b1; a = ch; m_k_in = val;
      @(negedge clk_pid);
      ce = 1'b0;
   endtask

   initial begin
      int h0, h1, nw, errs;
      reset = 1'b1; ce = 1'b0; a = '0; m_k_in = '0;
      repeat (3) @(negedge clk_pid);
      chk("rst_pwm", 32'(pwm_out), 0);
      chk("rst_dir", 32'(dir_out), 0);
      chk("rst_wrap", 32'(wrap), 0);
      reset = 1'b0;

      // 1: +512 on channel 0
      send(1'b0, 12'd512);
      wait_wrap();
      measure(h0, h1, nw);
      chk("t1_high0", 32'(h0), 512);
      chk("t1_high1", 32'(h1), 0);
      chk("t1_dir", 32'(dir_out), 0);
      chk("t1_wraps", 32'(nw), 1);

      // 2: reverse to -300
      send(1'b0, 12'hED4);
      wait_wrap();
`ifdef PID_PWM_DEADTIME_EN
      measure(h0, h1, nw);
      chk("t2_dead_high0", 32'(h0), 0);
      chk("t2_dead_dir", 32'(dir_out[0]), 0);
      wait_wrap();
`endif
      measure(h0, h1, nw);
      chk("t2_high0", 32'(h0), 300);
      chk("t2_dir0", 32'(dir_out[0]), 1);
      chk("t2_high1", 32'(h1), 0);

      // 3: most negative value on channel 1 saturates
      send(1'b1, 12'h800);
      wait_wrap();
      measure(h0, h1, nw);
      chk("t3_high1", 32'(h1), 2047);
      chk("t3_dir", 32'(dir_out), 3);
      chk("t3_high0", 32'(h0), 300);

      // 4: zero power keeps direction
      send(1'b0, 12'd0);
      wait_wrap();
      measure(h0, h1, nw);
      chk("t4_high0", 32'(h0), 0);
      chk("t4_dir0", 32'(dir_out[0]), 1);

      // 5: ce in the wrap cycle applies one period later
      wait_wrap();
      ce = 1'b1; a = 1'b0; m_k_in = 12'd100;
      @(negedge clk_pid);
      ce = 1'b0;
      h0 = int'(pwm_out[0]);
      repeat (period - 1) begin
         @(negedge clk_pid);
         h0 += int'(pwm_out[0]);
      end
      chk("t5_cur_high0", 32'(h0), 0);
      chk("t5_wrap_end", 32'(wrap), 1);
`ifdef PID_PWM_DEADTIME_EN
      repeat (2) wait_wrap();
`endif
      measure(h0, h1, nw);
      chk("t5_high0", 32'(h0), 100);
      chk("t5_dir0", 32'(dir_out[0]), 0);

      // 6: async reset while pwm_out[0] is high
      repeat (3) @(negedge clk_pid);
      chk("t6_pre_pwm0", 32'(pwm_out[0]), 1);
      #2 reset = 1'b1;
      #1;
      chk("t6_async_pwm", 32'(pwm_out), 0);
      chk("t6_async_dir", 32'(dir_out), 0);
      chk("t6_async_wrap", 32'(wrap), 0);
      repeat (3) @(negedge clk_pid);
      reset = 1'b0;
      errs = 0;
      repeat (2 * period + 100) begin
         @(negedge clk_pid);
         if (pwm_out != '0 || dir_out != '0) errs++;
      end
      chk("t6_quiet_after_reset", 32'(errs), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
